branch_target_predictor: RTL and testbench

Set-associative branch target buffer with per-entry 2-bit direction counters, sitting beside the fetch PC register in the front end. A lookup with the current fetch PC returns, one enabled cycle later, a hit flag, the predicted target and a taken/not-taken prediction. The execute stage writes resolved branches back through a single update port. Entries are allocated on taken branches only, with per-set round-robin replacement.

---
 rtl/branch_target_predictor_if.sv | 26 ++
 rtl/branch_target_predictor.sv | 156 +++++++++++++++
 tb/tb_branch_target_predictor.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_target_predictor_if.sv
// Lookup/update bus of the branch target predictor: fetch-side lookup, execute-side
// update, stall gate and flush. The master drives requests, the slave (predictor) answers.
interface branch_target_predictor_if #(
    parameter int PC_BITWIDTH = 30
) ();
    logic                   clk_en;
    logic                   flush;
    logic [PC_BITWIDTH-1:0] r_address;
    logic                   we;
    logic [PC_BITWIDTH-1:0] w_address;
    logic [PC_BITWIDTH-1:0] w_target;
    logic                   w_taken;
    logic                   hit;
    logic                   predict_taken;
    logic [PC_BITWIDTH-1:0] target;

    modport master (
        output clk_en, flush, r_address, we, w_address, w_target, w_taken,
        input  hit, predict_taken, target
    );

    modport slave (
        input  clk_en, flush, r_address, we, w_address, w_target, w_taken,
        output hit, predict_taken, target
    );
endinterface

// File: rtl/branch_target_predictor.sv
// Set-associative BTB with 2-bit direction counters and per-set round-robin replacement.
// Optional macro BTB_WRITE_BYPASS_EN forwards a same-address update into the lookup result.
module branch_target_predictor #(
    parameter int PC_BITWIDTH    = 30,
    parameter int INDEX_BITWIDTH = 4,
    parameter int WAYS           = 2
) (
    input  logic                      clk,
    input  logic                      async_rst_n,
    branch_target_predictor_if.slave  bus
);
    localparam int SETS    = 2 ** INDEX_BITWIDTH;
    localparam int TAGSIZE = PC_BITWIDTH - INDEX_BITWIDTH;
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef logic [WAY_W-1:0] way_t;

    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'd1;
        else    return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    logic [WAYS-1:0]        valid   [SETS];
    way_t                   rr      [SETS];
    logic [TAGSIZE-1:0]     tag_mem [SETS][WAYS];
    logic [PC_BITWIDTH-1:0] tgt_mem [SETS][WAYS];
    logic [1:0]             ctr_mem [SETS][WAYS];

    logic [INDEX_BITWIDTH-1:0] r_idx, w_idx;
    logic [TAGSIZE-1:0]        r_tag, w_tag;

    assign r_idx = bus.r_address[INDEX_BITWIDTH-1:0];
    assign r_tag = bus.r_address[PC_BITWIDTH-1:INDEX_BITWIDTH];
    assign w_idx = bus.w_address[INDEX_BITWIDTH-1:0];
    assign w_tag = bus.w_address[PC_BITWIDTH-1:INDEX_BITWIDTH];

    logic                   r_hit, r_msb;
    logic [PC_BITWIDTH-1:0] r_tgt;

    always_comb begin
        r_hit = 1'b0;
        r_msb = 1'b0;
        r_tgt = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (valid[r_idx][i] && tag_mem[r_idx][i] == r_tag) begin
                r_hit = 1'b1;
                r_msb = ctr_mem[r_idx][i][1];
                r_tgt = tgt_mem[r_idx][i];
            end
        end
    end

    logic       w_hit, any_free;
    way_t       w_way, free_way, victim, rr_next;
    logic [1:0] w_ctr;

    always_comb begin
        w_hit    = 1'b0;
        w_way    = '0;
        w_ctr    = '0;
        any_free = 1'b0;
        free_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (valid[w_idx][i] && tag_mem[w_idx][i] == w_tag) begin
                w_hit = 1'b1;
                w_way = way_t'(i);
                w_ctr = ctr_mem[w_idx][i];
            end
        end
        // Descending scan so the lowest-numbered invalid way wins.
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid[w_idx][i]) begin
                any_free = 1'b1;
                free_way = way_t'(i);
            end
        end
    end

    assign victim  = any_free ? free_way : rr[w_idx];
    assign rr_next = (rr[w_idx] == way_t'(WAYS - 1)) ? '0 : rr[w_idx] + 1'b1;

    logic do_write, do_upd, do_alloc;

    assign do_write = bus.clk_en && !bus.flush && bus.we;
    assign do_upd   = do_write && w_hit;
    assign do_alloc = do_write && !w_hit && bus.w_taken;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                rr[s]    <= '0;
            end
        end else if (bus.clk_en && bus.flush) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                rr[s]    <= '0;
            end
        end else if (do_alloc) begin
            valid[w_idx][victim] <= 1'b1;
            if (!any_free) rr[w_idx] <= rr_next;
        end
    end

    // Payload arrays carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if (do_upd) begin
            tgt_mem[w_idx][w_way] <= bus.w_target;
            ctr_mem[w_idx][w_way] <= ctr_step(w_ctr, bus.w_taken);
        end else if (do_alloc) begin
            tag_mem[w_idx][victim] <= w_tag;
            tgt_mem[w_idx][victim] <= bus.w_target;
            ctr_mem[w_idx][victim] <= 2'b10;
        end
    end

`ifdef BTB_WRITE_BYPASS_EN
    logic       bypass;
    logic [1:0] byp_ctr;

    assign bypass  = bus.we && (bus.w_address == bus.r_address) && (w_hit || bus.w_taken);
    assign byp_ctr = w_hit ? ctr_step(w_ctr, bus.w_taken) : 2'b10;
`endif

    // ---- lookup result register (p1) ----
    logic                   hit_p1, predict_taken_p1;
    logic [PC_BITWIDTH-1:0] target_p1;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            hit_p1           <= 1'b0;
            predict_taken_p1 <= 1'b0;
            target_p1        <= '0;
        end else if (bus.clk_en) begin
            if (bus.flush) begin
                hit_p1           <= 1'b0;
                predict_taken_p1 <= 1'b0;
                target_p1        <= '0;
`ifdef BTB_WRITE_BYPASS_EN
            end else if (bypass) begin
                hit_p1           <= 1'b1;
                predict_taken_p1 <= byp_ctr[1];
                target_p1        <= bus.w_target;
`endif
            end else begin
                hit_p1           <= r_hit;
                predict_taken_p1 <= r_hit && r_msb;
                target_p1        <= r_tgt;
            end
        end
    end

    assign bus.hit           = hit_p1;
    assign bus.predict_taken = predict_taken_p1;
    assign bus.target        = target_p1;
endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench for branch_target_predictor: directed lookups/updates push expected
// {hit, predict_taken, target} into a queue; a negedge monitor pops and compares.
module tb_branch_target_predictor;
    localparam int PCW = 30;

    logic clk = 1'b0;
    logic async_rst_n = 1'b0;

    branch_target_predictor_if #(.PC_BITWIDTH(PCW)) bus ();

    branch_target_predictor #(
        .PC_BITWIDTH(PCW),
        .INDEX_BITWIDTH(4),
        .WAYS(2)
    ) dut (
        .clk(clk),
        .async_rst_n(async_rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] v;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          passed = 0;
    logic        req = 1'b0;
    logic        chk_vld;
    logic [31:0] dut_out;

    assign dut_out = {bus.hit, bus.predict_taken, bus.target};

    function automatic logic [31:0] pack(input logic h, input logic p, input logic [PCW-1:0] t);
        return {h, p, t};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got hit=%0b predict_taken=%0b target=0x%0h, required hit=%0b predict_taken=%0b target=0x%0h",
                      name, act[31], act[30], act[29:0], exp[31], exp[30], exp[29:0]);
    endtask

    // A lookup presented on an enabled edge produces a result to check one cycle later.
    always @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) chk_vld <= 1'b0;
        else              chk_vld <= req && bus.clk_en;
    end

    always @(negedge clk) begin
        exp_t e;
        if (chk_vld) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_output: got 0x%0h with no expectation queued", dut_out);
            end else begin
                e = exp_q.pop_front();
                check(e.name, dut_out, e.v);
            end
        end
    end

    task automatic op(input string nm, input logic lk, input logic [PCW-1:0] ra,
                      input logic wr, input logic [PCW-1:0] wa, input logic [PCW-1:0] wt,
                      input logic tk, input logic fl,
                      input logic eh, input logic ep, input logic [PCW-1:0] et);
        exp_t e;
        @(negedge clk);
        bus.r_address = ra;
        bus.we        = wr;
        bus.w_address = wa;
        bus.w_target  = wt;
        bus.w_taken   = tk;
        bus.flush     = fl;
        req           = lk;
        if (lk) begin
            e.name = nm;
            e.v    = pack(eh, ep, et);
            exp_q.push_back(e);
        end
    endtask

    task automatic look(input string nm, input logic [PCW-1:0] ra,
                        input logic eh, input logic ep, input logic [PCW-1:0] et);
        op(nm, 1'b1, ra, 1'b0, '0, '0, 1'b0, 1'b0, eh, ep, et);
    endtask

    task automatic upd(input logic [PCW-1:0] wa, input logic [PCW-1:0] wt, input logic tk);
        op("", 1'b0, '0, 1'b1, wa, wt, tk, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic idle();
        op("", 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1);
    end

    initial begin
        bus.clk_en    = 1'b1;
        bus.flush     = 1'b0;
        bus.r_address = '0;
        bus.we        = 1'b0;
        bus.w_address = '0;
        bus.w_target  = '0;
        bus.w_taken   = 1'b0;

        #12 check("reset_state", dut_out, pack(1'b0, 1'b0, '0));
        @(negedge clk);
        async_rst_n = 1'b1;

        look("miss_after_reset", 30'h100, 1'b0, 1'b0, '0);

        // Counter walk on 0x100
        upd(30'h100, 30'h2000, 1'b1);
        look("alloc_ctr2", 30'h100, 1'b1, 1'b1, 30'h2000);
        upd(30'h100, 30'h2000, 1'b0);
        look("ctr1", 30'h100, 1'b1, 1'b0, 30'h2000);
        upd(30'h100, 30'h2000, 1'b0);
        look("ctr0", 30'h100, 1'b1, 1'b0, 30'h2000);
        upd(30'h100, 30'h2000, 1'b0);
        upd(30'h100, 30'h2000, 1'b1);
        look("ctr_floor", 30'h100, 1'b1, 1'b0, 30'h2000);
        upd(30'h100, 30'h2222, 1'b1);
        look("ctr2_new_target", 30'h100, 1'b1, 1'b1, 30'h2222);
        upd(30'h100, 30'h2222, 1'b1);
        upd(30'h100, 30'h2222, 1'b1);
        upd(30'h100, 30'h2222, 1'b0);
        look("ctr_ceiling", 30'h100, 1'b1, 1'b1, 30'h2222);

        // Flush with simultaneous lookup and ignored write
        op("flush_same_cycle", 1'b1, 30'h100, 1'b1, 30'h300, 30'h5, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        look("flushed_100", 30'h100, 1'b0, 1'b0, '0);
        look("flush_drops_write", 30'h300, 1'b0, 1'b0, '0);

        // Round-robin replacement in set 0
        upd(30'h010, 30'hA, 1'b1);
        upd(30'h020, 30'hB, 1'b1);
        upd(30'h030, 30'hC, 1'b1);
        look("rr_020_hit", 30'h020, 1'b1, 1'b1, 30'hB);
        look("rr_030_hit", 30'h030, 1'b1, 1'b1, 30'hC);
        look("rr_010_evicted", 30'h010, 1'b0, 1'b0, '0);
        upd(30'h040, 30'hE, 1'b0);
        look("nt_no_alloc", 30'h040, 1'b0, 1'b0, '0);
        look("nt_020_kept", 30'h020, 1'b1, 1'b1, 30'hB);
        look("nt_030_kept", 30'h030, 1'b1, 1'b1, 30'hC);
        upd(30'h050, 30'hD, 1'b1);
        look("rr_020_evicted", 30'h020, 1'b0, 1'b0, '0);
        look("rr_050_hit", 30'h050, 1'b1, 1'b1, 30'hD);
        look("rr_030_hit2", 30'h030, 1'b1, 1'b1, 30'hC);

        // Stall: outputs and contents frozen
        look("pre_stall", 30'h030, 1'b1, 1'b1, 30'hC);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.clk_en    = 1'b0;
            req           = 1'b0;
            bus.r_address = 30'h050 + 30'(i);
            bus.we        = 1'b1;
            bus.w_address = 30'h030;
            bus.w_target  = 30'h999;
            bus.w_taken   = 1'b0;
            bus.flush     = (i == 1);
            @(posedge clk);
            #1 check("stall_hold", dut_out, pack(1'b1, 1'b1, 30'hC));
        end
        bus.we     = 1'b0;
        bus.flush  = 1'b0;
        bus.clk_en = 1'b1;
        look("post_stall_030", 30'h030, 1'b1, 1'b1, 30'hC);
        look("post_stall_050", 30'h050, 1'b1, 1'b1, 30'hD);

        op("flush2", 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        look("flush2_030", 30'h030, 1'b0, 1'b0, '0);
        look("flush2_050", 30'h050, 1'b0, 1'b0, '0);

        // Same-cycle lookup and taken update on an empty set
`ifdef BTB_WRITE_BYPASS_EN
        op("same_cycle", 1'b1, 30'h100, 1'b1, 30'h100, 30'h4444, 1'b1, 1'b0, 1'b1, 1'b1, 30'h4444);
`else
        op("same_cycle", 1'b1, 30'h100, 1'b1, 30'h100, 30'h4444, 1'b1, 1'b0, 1'b0, 1'b0, '0);
`endif
        look("same_cycle_after", 30'h100, 1'b1, 1'b1, 30'h4444);

        // Asynchronous reset between edges
        upd(30'h1A5, 30'h77, 1'b1);
        look("pre_reset_1a5", 30'h1A5, 1'b1, 1'b1, 30'h77);
        idle();
        idle();
        #2 async_rst_n = 1'b0;
        #1 check("async_reset_outputs", dut_out, pack(1'b0, 1'b0, '0));
        @(negedge clk);
        async_rst_n = 1'b1;
        look("post_reset_1a5", 30'h1A5, 1'b0, 1'b0, '0);
        look("post_reset_100", 30'h100, 1'b0, 1'b0, '0);
        upd(30'h1A5, 30'h88, 1'b1);
        look("post_reset_alloc", 30'h1A5, 1'b1, 1'b1, 30'h88);
        idle();
        idle();

        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d pending expectations, required 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
